// File: rtl/piso_serializer.sv
// piso_serializer: captures a WIDTH-bit word on load and shifts it out one bit per clock
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  output logic             s_out,
  output logic             s_valid,
  output logic             ready,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_next_sr;
  always_comb begin
    w_last    = (r_state == SHIFT) && (r_cnt == '0);
    ready     = (r_state == IDLE) || w_last;
    w_accept  = load && ready;
    w_next_sr = (MSB_FIRST != 0) ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
    s_valid   = (r_state == SHIFT);
    s_out     = s_valid && ((MSB_FIRST != 0) ? r_sr[WIDTH-1] : r_sr[0]);
    done      = r_done;
  end
  // counter holds at 0 when a word ends without a follow-on load
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_state <= SHIFT;
        r_sr    <= p_in;
        r_cnt   <= CW'(WIDTH - 1);
      end else if (r_state == SHIFT) begin
        r_sr    <= w_next_sr;
        r_cnt   <= w_last ? r_cnt : r_cnt - 1'b1;
        r_state <= w_last ? IDLE : SHIFT;
      end
    end
  end
endmodule
